// File: rtl/carregador_programa_pkg.sv
// -----------------------------------------------------------------------------
// carregador_programa_pkg
// Shared definitions for the program loader and the CPU side that consumes
// the program memory: loader state encoding, field positions inside a loader
// byte, default memory depth and small field-extraction helpers.
// -----------------------------------------------------------------------------
package carregador_programa_pkg;

   // Default program memory geometry (depth in words and address width).
   localparam int PALAVRAS_MAX_PADRAO = 16;
   localparam int LARGURA_END_PADRAO  = 4;

   // Field layout of one loader byte.
   localparam int BIT_FIM    = 7;
   localparam int INSTR_MSB  = 6;
   localparam int INSTR_LSB  = 4;
   localparam int VALOR_MSB  = 3;
   localparam int VALOR_LSB  = 0;

   // Loader states.
   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      CARREGANDO = 2'd1,
      CONCLUIDO  = 2'd2,
      ERRO       = 2'd3
   } estado_t;

   // True when the byte is the end-of-program marker.
   function automatic logic eh_fim(input logic [7:0] b);
      return b[BIT_FIM];
   endfunction

   // Opcode field of a loader byte.
   function automatic logic [2:0] campo_instrucao(input logic [7:0] b);
      return b[INSTR_MSB:INSTR_LSB];
   endfunction

   // Operand field of a loader byte.
   function automatic logic [3:0] campo_valor(input logic [7:0] b);
      return b[VALOR_MSB:VALOR_LSB];
   endfunction

endpackage

// File: rtl/carregador_programa_contador.sv
// -----------------------------------------------------------------------------
// contador_endereco
// Generic up-counter with synchronous clear and count enable. Used by the
// loader as the write-address / word counter and reusable as a pc counter.
// Ports:
//   i_clock     rising-edge clock
//   i_reset_n   synchronous active-low reset (count -> 0)
//   i_limpar    synchronous clear (priority over enable)
//   i_habilitar count enable, +1 per cycle
//   o_contagem  current count
// -----------------------------------------------------------------------------
module contador_endereco #(
   parameter int LARGURA = 5
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_limpar,
   input  logic               i_habilitar,
   output logic [LARGURA-1:0] o_contagem
);

   logic [LARGURA-1:0] r_contagem;

   // Count register: reset and clear both return to zero, clear wins over enable.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_contagem <= '0;
      end else if (i_limpar) begin
         r_contagem <= '0;
      end else if (i_habilitar) begin
         r_contagem <= r_contagem + LARGURA'(1);
      end else begin
         r_contagem <= r_contagem;
      end
   end

   assign o_contagem = r_contagem;

endmodule

// File: rtl/carregador_programa.sv
// -----------------------------------------------------------------------------
// carregador_programa
// Loads a program byte stream into program memory while holding the CPU.
// Each data byte (bit7=0) becomes one memory word {instrucao, valor}; a byte
// with bit7=1 ends the load; a data byte arriving with memory full is an
// overflow error.
// Ports:
//   i_clock, i_reset_n         clock, synchronous active-low reset
//   i_inicio                   start / restart a load (one-cycle pulse)
//   i_dado_valido, i_dado      byte source handshake and data
//   o_dado_pronto              loader accepts a byte this cycle
//   o_mem_escrita              memory write strobe
//   o_mem_endereco             write address
//   o_mem_instrucao/o_mem_valor  word fields written to memory
//   o_cpu_parado               holds the CPU stopped
//   o_carregado, o_erro        load completed / overflow
//   o_palavras                 words written in current/last load
// -----------------------------------------------------------------------------
module carregador_programa
   import carregador_programa_pkg::*;
#(
   parameter int PALAVRAS_MAX = PALAVRAS_MAX_PADRAO,
   parameter int LARGURA_END  = LARGURA_END_PADRAO
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_inicio,
   input  logic                   i_dado_valido,
   input  logic [7:0]             i_dado,
   output logic                   o_dado_pronto,
   output logic                   o_mem_escrita,
   output logic [LARGURA_END-1:0] o_mem_endereco,
   output logic [2:0]             o_mem_instrucao,
   output logic [3:0]             o_mem_valor,
   output logic                   o_cpu_parado,
   output logic                   o_carregado,
   output logic                   o_erro,
   output logic [LARGURA_END:0]   o_palavras
);

   localparam logic [LARGURA_END:0] LIMITE_PALAVRAS = (LARGURA_END + 1)'(PALAVRAS_MAX);

   estado_t                r_estado;
   estado_t                w_proximo;
   logic                   w_aceito;
   logic                   w_escrever;
   logic                   w_limpar;
   logic [LARGURA_END:0]   w_contagem;

   logic                   r_mem_escrita;
   logic [LARGURA_END-1:0] r_mem_endereco;
   logic [2:0]             r_mem_instrucao;
   logic [3:0]             r_mem_valor;

   // dado_pronto is a pure state decode, so acceptance never loops back
   // through dado_valido.
   assign w_aceito = i_dado_valido && (r_estado == CARREGANDO);

   // State register.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_proximo;
      end
   end

   // Next-state and counter control.
   always_comb begin
      w_proximo  = r_estado;
      w_escrever = 1'b0;
      w_limpar   = 1'b0;
      case (r_estado)
         CARREGANDO: begin
            if (i_inicio) begin
               // Restart: a byte accepted in this cycle is dropped.
               w_limpar = 1'b1;
            end else if (w_aceito) begin
               if (eh_fim(i_dado)) begin
                  w_proximo = CONCLUIDO;
               end else if (w_contagem == LIMITE_PALAVRAS) begin
                  w_proximo = ERRO;
               end else begin
                  w_escrever = 1'b1;
               end
            end else begin
               w_proximo = CARREGANDO;
            end
         end
         OCIOSO, CONCLUIDO, ERRO: begin
            if (i_inicio) begin
               w_proximo = CARREGANDO;
               w_limpar  = 1'b1;
            end else begin
               w_proximo = r_estado;
            end
         end
         default: begin
            w_proximo = OCIOSO;
         end
      endcase
   end

   // The counter is both the next write address (low bits) and the word
   // count; it stops at PALAVRAS_MAX because writes stop there.
   contador_endereco #(
      .LARGURA (LARGURA_END + 1)
   ) u_contador_endereco (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_limpar    (w_limpar),
      .i_habilitar (w_escrever),
      .o_contagem  (w_contagem)
   );

   // Memory write port registers: strobe one cycle after acceptance, fields
   // hold their last value when no write occurs.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_mem_escrita   <= 1'b0;
         r_mem_endereco  <= '0;
         r_mem_instrucao <= 3'd0;
         r_mem_valor     <= 4'd0;
      end else if (w_escrever) begin
         r_mem_escrita   <= 1'b1;
         r_mem_endereco  <= w_contagem[LARGURA_END-1:0];
         r_mem_instrucao <= campo_instrucao(i_dado);
         r_mem_valor     <= campo_valor(i_dado);
      end else begin
         r_mem_escrita   <= 1'b0;
         r_mem_endereco  <= r_mem_endereco;
         r_mem_instrucao <= r_mem_instrucao;
         r_mem_valor     <= r_mem_valor;
      end
   end

   assign o_dado_pronto   = (r_estado == CARREGANDO);
   assign o_cpu_parado    = (r_estado == CARREGANDO) || (r_estado == ERRO);
   assign o_carregado     = (r_estado == CONCLUIDO);
   assign o_erro          = (r_estado == ERRO);
   assign o_palavras      = w_contagem;
   assign o_mem_escrita   = r_mem_escrita;
   assign o_mem_endereco  = r_mem_endereco;
   assign o_mem_instrucao = r_mem_instrucao;
   assign o_mem_valor     = r_mem_valor;

endmodule

// File: tb/tb_carregador_programa.sv
// -----------------------------------------------------------------------------
// tb_carregador_programa
// Directed stimulus for the program loader. A behavioural model tracks the
// loader phase and word count from the byte stream and is compared with the
// DUT on every falling edge; directed tests add literal expectations on the
// logged memory writes and final status.
// -----------------------------------------------------------------------------
module tb_carregador_programa;
   import carregador_programa_pkg::*;

   localparam int MAXP = 16;

   logic       clk;
   logic       reset_n;
   logic       inicio;
   logic       dado_valido;
   logic [7:0] dado;
   logic       dado_pronto;
   logic       mem_escrita;
   logic [3:0] mem_endereco;
   logic [2:0] mem_instrucao;
   logic [3:0] mem_valor;
   logic       cpu_parado;
   logic       carregado;
   logic       erro;
   logic [4:0] palavras;

   carregador_programa #(.PALAVRAS_MAX(16), .LARGURA_END(4)) dut (
      .i_clock         (clk),
      .i_reset_n       (reset_n),
      .i_inicio        (inicio),
      .i_dado_valido   (dado_valido),
      .i_dado          (dado),
      .o_dado_pronto   (dado_pronto),
      .o_mem_escrita   (mem_escrita),
      .o_mem_endereco  (mem_endereco),
      .o_mem_instrucao (mem_instrucao),
      .o_mem_valor     (mem_valor),
      .o_cpu_parado    (cpu_parado),
      .o_carregado     (carregado),
      .o_erro          (erro),
      .o_palavras      (palavras)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int erros = 0;
   int total = 0;
   int ciclo_n = 0;

   logic [10:0] q_escritas[$];
   int          q_ciclo[$];

   // Model: phase of the load and words stored so far.
   localparam int FASE_PARADO = 0;
   localparam int FASE_CARGA  = 1;
   localparam int FASE_PRONTO = 2;
   localparam int FASE_ERRO   = 3;
   int         m_fase  = FASE_PARADO;
   int         m_pal   = 0;
   bit         m_ativo = 1'b0;
   bit         m_esc   = 1'b0;
   int         m_end   = 0;
   int         m_ins   = 0;
   int         m_val   = 0;

   task automatic verifica(input string nome, input int atual, input int esperado);
      total = total + 1;
      if (atual !== esperado) begin
         erros = erros + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, ciclo_n);
      end
   endtask

   function automatic int entrada(input int i);
      if (i < q_escritas.size()) return int'(q_escritas[i]);
      else return 32'hFFFF;
   endfunction

   // Model step at every rising edge, from the sampled inputs.
   task automatic modelo_passo();
      m_esc = 1'b0;
      if (!reset_n) begin
         m_fase  = FASE_PARADO;
         m_pal   = 0;
         m_ativo = 1'b1;
      end else if (m_fase == FASE_CARGA) begin
         if (inicio) begin
            m_pal = 0;
         end else if (dado_valido) begin
            if (dado[7]) begin
               m_fase = FASE_PRONTO;
            end else if (m_pal == MAXP) begin
               m_fase = FASE_ERRO;
            end else begin
               m_esc = 1'b1;
               m_end = m_pal;
               m_ins = int'(dado[6:4]);
               m_val = int'(dado[3:0]);
               m_pal = m_pal + 1;
            end
         end
      end else if (inicio) begin
         m_fase = FASE_CARGA;
         m_pal  = 0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         ciclo_n = ciclo_n + 1;
         modelo_passo();
      end
   end

   // Per-cycle comparison against the model plus write logging.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_escrita === 1'b1) begin
            q_escritas.push_back({mem_endereco, mem_instrucao, mem_valor});
            q_ciclo.push_back(ciclo_n);
         end
         if (m_ativo) begin
            verifica("m_pronto",   int'(dado_pronto), int'(m_fase == FASE_CARGA));
            verifica("m_parado",   int'(cpu_parado),
                     int'(m_fase == FASE_CARGA || m_fase == FASE_ERRO));
            verifica("m_carregado", int'(carregado), int'(m_fase == FASE_PRONTO));
            verifica("m_erro",     int'(erro), int'(m_fase == FASE_ERRO));
            verifica("m_palavras", int'(palavras), m_pal);
            verifica("m_escrita",  int'(mem_escrita), int'(m_esc));
            if (m_esc) begin
               verifica("m_endereco", int'(mem_endereco), m_end);
               verifica("m_instrucao", int'(mem_instrucao), m_ins);
               verifica("m_valor",    int'(mem_valor), m_val);
            end
         end
      end
   end

   task automatic ciclo();
      @(posedge clk);
      #2;
   endtask

   task automatic limpa_log();
      q_escritas.delete();
      q_ciclo.delete();
   endtask

   task automatic pulso_inicio();
      inicio = 1'b1;
      ciclo();
      inicio = 1'b0;
   endtask

   task automatic envia(input logic [7:0] b);
      dado_valido = 1'b1;
      dado        = b;
      ciclo();
      dado_valido = 1'b0;
   endtask

   initial begin
      reset_n     = 1'b0;
      inicio      = 1'b0;
      dado_valido = 1'b0;
      dado        = 8'h00;
      ciclo();
      ciclo();

      // Reset state
      verifica("rst_pronto",   int'(dado_pronto), 0);
      verifica("rst_parado",   int'(cpu_parado), 0);
      verifica("rst_carregado", int'(carregado), 0);
      verifica("rst_erro",     int'(erro), 0);
      verifica("rst_palavras", int'(palavras), 0);
      verifica("rst_escrita",  int'(mem_escrita), 0);
      reset_n = 1'b1;
      ciclo();

      // Two words then end marker, back-to-back
      limpa_log();
      pulso_inicio();
      dado_valido = 1'b1;
      dado = 8'h15; ciclo();
      dado = 8'h2A; ciclo();
      dado = 8'h80; ciclo();
      dado_valido = 1'b0;
      ciclo(); ciclo();
      verifica("t1_nwrites", q_escritas.size(), 2);
      verifica("t1_w0", entrada(0), int'({4'h0, 3'h1, 4'h5}));
      verifica("t1_w1", entrada(1), int'({4'h1, 3'h2, 4'hA}));
      if (q_ciclo.size() == 2) verifica("t1_consec", q_ciclo[1] - q_ciclo[0], 1);
      else verifica("t1_consec", q_ciclo.size(), 2);
      verifica("t1_carregado", int'(carregado), 1);
      verifica("t1_palavras",  int'(palavras), 2);
      verifica("t1_parado",    int'(cpu_parado), 0);

      // Overflow: 16 words then one more data byte
      limpa_log();
      pulso_inicio();
      dado_valido = 1'b1;
      for (int i = 0; i < 16; i++) begin
         dado = 8'(((i % 8) * 16) + (15 - i));
         ciclo();
      end
      dado = 8'h07; ciclo();
      dado_valido = 1'b0;
      ciclo(); ciclo();
      verifica("t2_nwrites", q_escritas.size(), 16);
      for (int i = 0; i < 16; i++) begin
         verifica($sformatf("t2_w%0d", i), entrada(i),
                  int'({4'(i), 3'(i % 8), 4'(15 - i)}));
      end
      verifica("t2_erro",     int'(erro), 1);
      verifica("t2_parado",   int'(cpu_parado), 1);
      verifica("t2_palavras", int'(palavras), 16);
      verifica("t2_carregado", int'(carregado), 0);

      // End marker as the first byte
      limpa_log();
      pulso_inicio();
      envia(8'h80);
      ciclo();
      verifica("t3_nwrites",  q_escritas.size(), 0);
      verifica("t3_carregado", int'(carregado), 1);
      verifica("t3_palavras", int'(palavras), 0);
      verifica("t3_erro",     int'(erro), 0);

      // dado_valido toggling each cycle
      limpa_log();
      pulso_inicio();
      envia(8'h11); dado = 8'h99; ciclo();
      envia(8'h22); dado = 8'h99; ciclo();
      envia(8'h33); ciclo();
      verifica("t4_nwrites", q_escritas.size(), 3);
      verifica("t4_w0", entrada(0), int'({4'h0, 3'h1, 4'h1}));
      verifica("t4_w1", entrada(1), int'({4'h1, 3'h2, 4'h2}));
      verifica("t4_w2", entrada(2), int'({4'h2, 3'h3, 4'h3}));
      verifica("t4_palavras", int'(palavras), 3);
      envia(8'h80);
      ciclo();

      // Restart with a byte in the same cycle
      limpa_log();
      pulso_inicio();
      dado_valido = 1'b1;
      for (int i = 0; i < 5; i++) begin
         dado = 8'(8'h41 + i);
         ciclo();
      end
      inicio = 1'b1; dado = 8'h66; ciclo();
      inicio = 1'b0;
      dado = 8'h33; ciclo();
      dado = 8'h80; ciclo();
      dado_valido = 1'b0;
      ciclo(); ciclo();
      verifica("t5_nwrites", q_escritas.size(), 6);
      verifica("t5_w0", entrada(0), int'({4'h0, 3'h4, 4'h1}));
      verifica("t5_w4", entrada(4), int'({4'h4, 3'h4, 4'h5}));
      verifica("t5_w5", entrada(5), int'({4'h0, 3'h3, 4'h3}));
      verifica("t5_palavras",  int'(palavras), 1);
      verifica("t5_carregado", int'(carregado), 1);

      // Reset in the cycle a data byte is accepted
      limpa_log();
      pulso_inicio();
      envia(8'h12);
      dado_valido = 1'b1; dado = 8'h44; reset_n = 1'b0;
      ciclo();
      dado_valido = 1'b0;
      verifica("t6_escrita",  int'(mem_escrita), 0);
      verifica("t6_pronto",   int'(dado_pronto), 0);
      verifica("t6_parado",   int'(cpu_parado), 0);
      verifica("t6_carregado", int'(carregado), 0);
      verifica("t6_erro",     int'(erro), 0);
      verifica("t6_palavras", int'(palavras), 0);
      reset_n = 1'b1;
      ciclo(); ciclo();
      verifica("t6_nwrites", q_escritas.size(), 1);

      $display("Result: errors=%0d of %0d checks", erros, total);
      $finish;
   end

endmodule

// File: doc/carregador_programa.md
CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 Parameter PALAVRAS_MAX, default 16; program memory depth in words, power of two, 2..16.
REQ-002 Parameter LARGURA_END, default 4; memory address width, equal to log2(PALAVRAS_MAX).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 inicio  in  1  one-cycle pulse; starts or restarts a program load.
REQ-006 dado_valido  in  1  source presents a byte on dado.
REQ-007 dado  in  8  bit7 = end marker; bits6:4 = instrucao; bits3:0 = valor.
REQ-008 dado_pronto  out  1  loader accepts a byte this cycle.
REQ-009 mem_escrita  out  1  write strobe to program memory.
REQ-010 mem_endereco  out  LARGURA_END  write address.
REQ-011 mem_instrucao  out  3  opcode field to memory.
REQ-012 mem_valor  out  4  operand field to memory.
REQ-013 cpu_parado  out  1  holds the CPU (pc and registers) stopped while high.
REQ-014 carregado  out  1  a complete, error-free program is in memory.
REQ-015 erro  out  1  overflow: data word received with memory full.
REQ-016 palavras  out  LARGURA_END+1  number of words written in the current/last load.

Function
REQ-017 The loader SHALL implement states OCIOSO, CARREGANDO, CONCLUIDO, ERRO.
REQ-018 A byte SHALL be accepted only in a cycle where dado_valido and dado_pronto are both 1.
REQ-019 dado_pronto SHALL be 1 only in CARREGANDO; it depends on state only, never combinationally on dado_valido.
REQ-020 OCIOSO/CONCLUIDO/ERRO: inicio=1 SHALL go to CARREGANDO and clear palavras, erro and carregado; the address counter SHALL return to 0.
REQ-021 CARREGANDO: inicio=1 SHALL restart the load (palavras=0, address 0); any byte accepted in that same cycle SHALL be discarded.
REQ-022 An accepted byte with bit7=0 and palavras<PALAVRAS_MAX SHALL produce exactly one write: mem_escrita=1 in the next cycle, with mem_endereco=palavras (pre-increment), mem_instrucao=dado[6:4], mem_valor=dado[3:0].
REQ-023 After each write, palavras SHALL increment by 1; the address SHALL never wrap within a load.
REQ-024 An accepted byte with bit7=1 SHALL cause no write and SHALL move to CONCLUIDO next cycle; bits6:0 are ignored.
REQ-025 An end marker as the first byte SHALL yield CONCLUIDO with palavras=0 and carregado=1.
REQ-026 An accepted byte with bit7=0 and palavras=PALAVRAS_MAX SHALL cause no write, set erro=1, and move to ERRO.
REQ-027 Back-to-back bytes (dado_valido held high) SHALL be accepted one per cycle with no bubbles.
REQ-028 cpu_parado SHALL be 1 in CARREGANDO and ERRO, 0 in OCIOSO and CONCLUIDO.
REQ-029 carregado SHALL be 1 exactly while in CONCLUIDO; erro SHALL be 1 exactly while in ERRO.
REQ-030 mem_escrita SHALL be 0 in every cycle not covered by REQ-022; mem_endereco/mem_instrucao/mem_valor are don't-care when mem_escrita=0 but SHALL be registered.

Reset
REQ-031 reset_n=0 at a clock edge SHALL force OCIOSO, palavras=0, address 0, and all outputs 0 the following cycle, overriding inicio and any handshake.
REQ-032 A reset during CARREGANDO SHALL abort the load; a write already scheduled for the next cycle SHALL be suppressed.

Structure
REQ-033 State encoding, field bit positions (FIM=7, INSTR=6:4, VALOR=3:0) and PALAVRAS_MAX default SHALL live in a shared package/include used by the CPU side too.
REQ-034 The write address SHALL come from one sub-module, contador_endereco (synchronous clear, enable, count output), reusable alongside the pc contador.

Verification
REQ-035 inicio, then bytes 0x15, 0x2A, 0x80 back-to-back -> writes (0,1,5) and (1,2,A) on consecutive cycles, then carregado=1, palavras=2, cpu_parado=0.
REQ-036 inicio, 16 data bytes, then 0x07 -> 16 writes addr 0..15, no 17th write, erro=1, cpu_parado=1, palavras=16.
REQ-037 inicio, first byte 0x80 -> no write, carregado=1, palavras=0.
REQ-038 inicio, 3 bytes with dado_valido toggling 1/0 each cycle -> exactly 3 writes, addresses 0,1,2, none duplicated.
REQ-039 inicio, 5 bytes, inicio together with a 6th byte, then 0x33, 0x80 -> 6th byte dropped, 0x33 written at address 0, palavras=1.
REQ-040 reset_n=0 in the cycle a data byte is accepted -> no mem_escrita next cycle, state OCIOSO, all outputs 0.
